// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Line geometry, memory latency and the fetch FSM state encoding.
package fetch_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned INST_W      = 16;
    localparam int unsigned LINE_W      = 64;
    localparam int unsigned MEM_LATENCY = 5;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    // A line is 8 bytes, so the tag is everything above the byte-in-line offset.
    localparam int unsigned TAG_W = ADDR_W - 3;
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic {
        StWait,
        StServe
    } fetch_state_e;

    function automatic logic [TAG_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:3];
    endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// One-line instruction buffer: holds a captured memory line with its tag,
// reports a combinational tag hit and selects one 16-bit word by pc[2:1].
module fetch_line_buffer
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_i,
    input  logic              invalidate_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [TAG_W-1:0]  lookup_tag_i,
    input  logic [1:0]        word_sel_i,
    output logic              hit_o,
    output logic [INST_W-1:0] word_o
);

    logic [LINE_W-1:0] line_d, line_q;
    logic [TAG_W-1:0]  tag_d, tag_q;
    logic              valid_d, valid_q;

    always_comb begin
        line_d  = line_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        if (capture_i) begin
            line_d  = line_i;
            tag_d   = tag_i;
            valid_d = 1'b1;
        end else if (invalidate_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            line_q  <= line_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    assign hit_o = valid_q && (tag_q == lookup_tag_i);

    always_comb begin
        word_o = '0;
        unique case (word_sel_i)
            2'd0: word_o = line_q[0*INST_W +: INST_W];
            2'd1: word_o = line_q[1*INST_W +: INST_W];
            2'd2: word_o = line_q[2*INST_W +: INST_W];
            2'd3: word_o = line_q[3*INST_W +: INST_W];
            default: word_o = '0;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches 8-byte lines with a fixed memory latency,
// and issues 16-bit instructions to decode under stall/redirect control.
module instruction_fetch_unit
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [LINE_W-1:0] mem_ins_i,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o
);

    fetch_state_e      state_d, state_q;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [TAG_W-1:0]  mem_line_d, mem_line_q;
    logic [CNT_W-1:0]  wait_cnt_d, wait_cnt_q;
    logic [INST_W-1:0] inst_d, inst_q;
    logic [ADDR_W-1:0] inst_pc_d, inst_pc_q;
    logic              inst_valid_d, inst_valid_q;

    logic [ADDR_W-1:0] target_pc;
    logic [ADDR_W-1:0] pc_next;
    logic              capture;
    logic              redirect_hit;
    logic [INST_W-1:0] buf_word;

    assign target_pc = redirect_pc_i & ~ADDR_W'(1);
    assign pc_next   = pc_q + ADDR_W'(2);

    // The buffer is never invalidated: a redirect back into the held line
    // is served without a refetch, even after the PC has moved on.
    fetch_line_buffer u_line_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture_i    (capture),
        .invalidate_i (1'b0),
        .line_i       (mem_ins_i),
        .tag_i        (mem_line_q),
        .lookup_tag_i (line_of(target_pc)),
        .word_sel_i   (pc_q[2:1]),
        .hit_o        (redirect_hit),
        .word_o       (buf_word)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_line_d   = mem_line_q;
        wait_cnt_d   = wait_cnt_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        capture      = 1'b0;

        if (redirect_valid_i) begin
            // Redirect beats stall, capture and line-crossing advances.
            inst_valid_d = 1'b0;
            pc_d         = target_pc;
            wait_cnt_d   = '0;
            if (redirect_hit) begin
                state_d = StServe;
            end else begin
                state_d    = StWait;
                mem_line_d = line_of(target_pc);
            end
        end else begin
            unique case (state_q)
                StWait: begin
                    if (!stall_i) begin
                        inst_valid_d = 1'b0;
                    end
                    if (wait_cnt_q == CNT_W'(MEM_LATENCY)) begin
                        capture    = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = StServe;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                StServe: begin
                    if (!inst_valid_q || !stall_i) begin
                        inst_d       = buf_word;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_next;
                        if (pc_q[2:1] == 2'b11) begin
                            state_d    = StWait;
                            mem_line_d = line_of(pc_next);
                            wait_cnt_d = '0;
                        end
                    end
                end
                default: state_d = StWait;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StWait;
            pc_q         <= RESET_PC;
            mem_line_q   <= line_of(RESET_PC);
            wait_cnt_q   <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_line_q   <= mem_line_d;
            wait_cnt_q   <= wait_cnt_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign mem_addr_o   = {mem_line_q, 3'b000};
    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;

endmodule
